// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the parametrised reorder buffer.
// Holds the instruction type encodings, the type field width, the per-entry
// record layout and a helper deciding whether a retiring entry writes the
// register file.
package rob_pkg;

    localparam int ROB_TYPE_W = 3;

    localparam logic [ROB_TYPE_W-1:0] ROB_ALU    = 3'd0;
    localparam logic [ROB_TYPE_W-1:0] ROB_LOAD   = 3'd1;
    localparam logic [ROB_TYPE_W-1:0] ROB_STORE  = 3'd2;
    localparam logic [ROB_TYPE_W-1:0] ROB_BRANCH = 3'd3;
    localparam logic [ROB_TYPE_W-1:0] ROB_JUMP   = 3'd4;

    // One reorder-buffer slot. The type field is called typ because "type"
    // is a keyword.
    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic                  mispred;
        logic [ROB_TYPE_W-1:0] typ;
        logic [4:0]            rd;
        logic [31:0]           value;
        logic [31:0]           rec_pc;
    } rob_entry_t;

    // Only result-producing types write a register, and x0 is never written.
    function automatic logic rob_writes_reg(input logic [ROB_TYPE_W-1:0] typ,
                                            input logic [4:0]            rd);
        logic is_wr_type;
        case (typ)
            ROB_ALU, ROB_LOAD, ROB_JUMP: is_wr_type = 1'b1;
            default:                     is_wr_type = 1'b0;
        endcase
        return is_wr_type && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/rob_param_chk.sv
// rob_param_chk: protocol checker for the reorder buffer. Flags a decoder
// that requests allocation while the buffer is full; the request itself is
// dropped by the buffer.
// Ports: clk, rst, rdy, iss_valid, iss_ready.
module rob_param_chk (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic iss_valid,
    input logic iss_ready
);

    issue_while_full_a: assert property (@(posedge clk) disable iff (rst)
        !(rdy && iss_valid && !iss_ready))
        else $warning("rob_param: issue request while full was dropped");

endmodule

// File: rtl/rob_param_lookup.sv
// rob_lookup: combinational operand query against the reorder buffer.
// A tag is ready when its stored entry is busy and ready, or when any
// writeback port delivers it this cycle. Writeback port 0 has the highest
// priority, then higher ports, then the stored value.
// Ports: q_tag (query), busy/ready/value (flattened entry state),
//        wb_valid/wb_tag/wb_value (packed writeback ports),
//        q_ready/q_value (result).
module rob_lookup #(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2,
    parameter int IDX_W    = 3
) (
    input  logic [IDX_W-1:0]          q_tag,
    input  logic [DEPTH-1:0]          busy,
    input  logic [DEPTH-1:0]          ready,
    input  logic [DEPTH-1:0][31:0]    value,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    output logic                      q_ready,
    output logic [31:0]               q_value
);

    // Stored value first, then overlay writebacks from the highest port down
    // so that port 0 is applied last and wins.
    always_comb begin
        q_ready = busy[q_tag] && ready[q_tag];
        q_value = value[q_tag];
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_tag[p*IDX_W +: IDX_W] == q_tag)) begin
                q_ready = 1'b1;
                q_value = wb_value[p*32 +: 32];
            end else begin
                q_value = q_value;
            end
        end
    end

endmodule

// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
// Allocation (iss_*), writeback (wb_*), two operand queries (q_*),
// in-order commit (cm_*), store handshake (st_req/st_ack), mispredict
// flush (flush/flush_pc) and status (head_tag/count/empty). rdy low freezes
// all state and suppresses commit, flush and store requests.
module rob_param
    import rob_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int WB_PORTS = 2,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [2:0]                iss_type,
    input  logic [4:0]                iss_rd,
    input  logic                      iss_done,
    input  logic [31:0]               iss_value,
    input  logic [31:0]               iss_rec_pc,
    output logic [IDX_W-1:0]          iss_tag,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]    wb_value,
    input  logic [WB_PORTS-1:0]       wb_mispred,
    input  logic [IDX_W-1:0]          q_tag1,
    input  logic [IDX_W-1:0]          q_tag2,
    output logic                      q_ready1,
    output logic                      q_ready2,
    output logic [31:0]               q_value1,
    output logic [31:0]               q_value2,
    output logic                      cm_valid,
    output logic                      cm_wr,
    output logic [4:0]                cm_rd,
    output logic [31:0]               cm_value,
    output logic [IDX_W-1:0]          cm_tag,
    output logic                      st_req,
    input  logic                      st_ack,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic [IDX_W-1:0]          head_tag,
    output logic [IDX_W:0]            count,
    output logic                      empty
);

    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);

    rob_entry_t            ent_r [DEPTH];
    logic [IDX_W-1:0]      head_r;
    logic [IDX_W-1:0]      tail_r;
    logic [IDX_W:0]        count_r;

    rob_entry_t            head_e_s;
    logic                  head_ok_s;
    logic                  iss_fire_s;
    logic [IDX_W-1:0]      wb_tag_s [WB_PORTS];
    logic [WB_PORTS-1:0]   wb_hit_s;
    logic [DEPTH-1:0]      busy_s;
    logic [DEPTH-1:0]      ready_s;
    logic [DEPTH-1:0][31:0] value_s;

    assign iss_ready = (count_r < DEPTH_CNT);
    assign iss_tag   = tail_r;
    assign head_tag  = head_r;
    assign count     = count_r;
    assign empty     = (count_r == {(IDX_W+1){1'b0}});
    assign head_e_s  = ent_r[head_r];
    assign head_ok_s = rdy && head_e_s.busy && head_e_s.ready;
    assign iss_fire_s = iss_valid && iss_ready && rdy && !flush;

    // Retire decision from head state; a mispredict retires and flushes at
    // once so a mispredicted JUMP still writes its link register.
    always_comb begin
        cm_valid = 1'b0;
        st_req   = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'd0;
        if (head_ok_s && head_e_s.mispred) begin
            flush    = 1'b1;
            flush_pc = head_e_s.rec_pc;
            cm_valid = 1'b1;
        end else if (head_ok_s && (head_e_s.typ == ROB_STORE)) begin
            st_req   = 1'b1;
            cm_valid = st_ack;
        end else if (head_ok_s) begin
            cm_valid = 1'b1;
        end else begin
            cm_valid = 1'b0;
        end
    end

    // Commit payload is held at zero unless an entry actually retires.
    always_comb begin
        cm_wr    = 1'b0;
        cm_rd    = 5'd0;
        cm_value = 32'd0;
        cm_tag   = {IDX_W{1'b0}};
        if (cm_valid) begin
            cm_wr    = rob_writes_reg(head_e_s.typ, head_e_s.rd);
            cm_rd    = head_e_s.rd;
            cm_value = head_e_s.value;
            cm_tag   = head_r;
        end else begin
            cm_wr    = 1'b0;
        end
    end

    // Unpack writeback tags and qualify each port against a busy entry.
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_tag_s[p] = wb_tag[p*IDX_W +: IDX_W];
            wb_hit_s[p] = wb_valid[p] && ent_r[wb_tag[p*IDX_W +: IDX_W]].busy;
        end
    end

    // Flatten entry state for the query units.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_s[i]  = ent_r[i].busy;
            ready_s[i] = ent_r[i].ready;
            value_s[i] = ent_r[i].value;
        end
    end

    // Buffer state: flush wins over issue and writeback; writebacks are
    // applied highest port first so port 0 overrides on a shared tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else if (!rdy) begin
            head_r <= head_r;
        end else if (flush) begin
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i].busy    <= 1'b0;
                ent_r[i].ready   <= 1'b0;
                ent_r[i].mispred <= 1'b0;
            end
        end else begin
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (wb_hit_s[p]) begin
                    ent_r[wb_tag_s[p]].ready   <= 1'b1;
                    ent_r[wb_tag_s[p]].value   <= wb_value[p*32 +: 32];
                    ent_r[wb_tag_s[p]].mispred <= wb_mispred[p];
                end
            end
            if (cm_valid) begin
                ent_r[head_r].busy  <= 1'b0;
                ent_r[head_r].ready <= 1'b0;
                head_r              <= head_r + IDX_ONE;
            end
            if (iss_fire_s) begin
                ent_r[tail_r] <= '{busy: 1'b1, ready: iss_done, mispred: 1'b0,
                                   typ: iss_type, rd: iss_rd, value: iss_value,
                                   rec_pc: iss_rec_pc};
                tail_r        <= tail_r + IDX_ONE;
            end
            count_r <= count_r + {{IDX_W{1'b0}}, iss_fire_s}
                               - {{IDX_W{1'b0}}, cm_valid};
        end
    end

    rob_lookup #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .IDX_W(IDX_W)) u_q1 (
        .q_tag(q_tag1), .busy(busy_s), .ready(ready_s), .value(value_s),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .q_ready(q_ready1), .q_value(q_value1)
    );

    rob_lookup #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .IDX_W(IDX_W)) u_q2 (
        .q_tag(q_tag2), .busy(busy_s), .ready(ready_s), .value(value_s),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .q_ready(q_ready2), .q_value(q_value2)
    );

    rob_param_chk u_chk (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid(iss_valid), .iss_ready(iss_ready)
    );

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed self-checking bench for rob_param (DEPTH=4,
// WB_PORTS=2). Inputs change 1ns after the rising edge; outputs are sampled
// before the next rising edge.
module tb_rob_param;
    import rob_pkg::*;

    localparam int DEPTH = 4;
    localparam int WBP   = 2;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rst, rdy, iss_valid, iss_done, st_ack;
    logic [2:0]        iss_type;
    logic [4:0]        iss_rd;
    logic [31:0]       iss_value, iss_rec_pc;
    logic [WBP-1:0]    wb_valid, wb_mispred;
    logic [WBP*IW-1:0] wb_tag;
    logic [WBP*32-1:0] wb_value;
    logic [IW-1:0]     q_tag1, q_tag2, iss_tag, cm_tag, head_tag;
    logic              iss_ready, q_ready1, q_ready2, cm_valid, cm_wr;
    logic              st_req, flush, empty;
    logic [31:0]       q_value1, q_value2, cm_value, flush_pc;
    logic [4:0]        cm_rd;
    logic [IW:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rob_param #(.DEPTH(DEPTH), .WB_PORTS(WBP)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_type(iss_type),
        .iss_rd(iss_rd), .iss_done(iss_done), .iss_value(iss_value),
        .iss_rec_pc(iss_rec_pc), .iss_tag(iss_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispred(wb_mispred),
        .q_tag1(q_tag1), .q_tag2(q_tag2), .q_ready1(q_ready1), .q_ready2(q_ready2),
        .q_value1(q_value1), .q_value2(q_value2),
        .cm_valid(cm_valid), .cm_wr(cm_wr), .cm_rd(cm_rd), .cm_value(cm_value),
        .cm_tag(cm_tag), .st_req(st_req), .st_ack(st_ack),
        .flush(flush), .flush_pc(flush_pc),
        .head_tag(head_tag), .count(count), .empty(empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [2:0] t, input logic [4:0] rd, input logic done,
                             input logic [31:0] val, input logic [31:0] pc);
        iss_valid  = 1'b1;
        iss_type   = t;
        iss_rd     = rd;
        iss_done   = done;
        iss_value  = val;
        iss_rec_pc = pc;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; iss_valid = 1'b0; iss_done = 1'b0; st_ack = 1'b0;
        iss_type = 3'd0; iss_rd = 5'd0; iss_value = 32'd0; iss_rec_pc = 32'd0;
        wb_valid = '0; wb_mispred = '0; wb_tag = '0; wb_value = '0;
        q_tag1 = '0; q_tag2 = '0;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_iss_ready", iss_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_cm_valid", cm_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_st_req", st_req, 0);
        check("rst_q_ready1", q_ready1, 0);

        // Fill, overfill attempt, then first retire
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(ROB_ALU, 5'(i + 1), 1'b0, 32'd0, 32'd0);
            check("fill_tag", iss_tag, i);
            step();
        end
        check("full_iss_ready", iss_ready, 0);
        check("full_count", count, DEPTH);
        check("full_tail", iss_tag, 0);
        step();
        iss_valid = 1'b0;
        check("ovf_count", count, DEPTH);
        check("ovf_tail", iss_tag, 0);
        wb_valid = 2'b01; wb_tag = {2'd3, 2'd0}; wb_value = {32'd0, 32'h11};
        q_tag1 = 2'd0;
        #1;
        check("wb_bypass_rdy", q_ready1, 1);
        check("wb_bypass_val", q_value1, 32'h11);
        check("wb_no_early_cm", cm_valid, 0);
        step();
        wb_valid = '0;
        #1;
        check("ret_cm_valid", cm_valid, 1);
        check("ret_cm_rd", cm_rd, 1);
        check("ret_cm_value", cm_value, 32'h11);
        check("ret_cm_wr", cm_wr, 1);
        check("ret_iss_ready_full", iss_ready, 0);
        step();
        check("ret_count", count, 3);
        check("ret_head", head_tag, 1);
        check("ret_iss_ready", iss_ready, 1);

        // LUI-style entry with known result
        do_reset();
        set_issue(ROB_ALU, 5'd5, 1'b1, 32'h12345000, 32'd0);
        check("lui_pre_cm", cm_valid, 0);
        step();
        iss_valid = 1'b0;
        check("lui_cm_valid", cm_valid, 1);
        check("lui_cm_wr", cm_wr, 1);
        check("lui_cm_rd", cm_rd, 5);
        check("lui_cm_value", cm_value, 32'h12345000);
        step();
        check("lui_empty", empty, 1);

        // Mispredicted branch at head flushes everything
        do_reset();
        set_issue(ROB_BRANCH, 5'd0, 1'b0, 32'd0, 32'h80); step();
        set_issue(ROB_ALU, 5'd1, 1'b0, 32'd0, 32'd0);     step();
        set_issue(ROB_ALU, 5'd2, 1'b0, 32'd0, 32'd0);     step();
        iss_valid = 1'b0;
        wb_valid = 2'b10; wb_mispred = 2'b10; wb_tag = {2'd0, 2'd3}; wb_value = '0;
        #1;
        check("br_no_early_flush", flush, 0);
        step();
        wb_valid = '0; wb_mispred = '0;
        set_issue(ROB_ALU, 5'd3, 1'b0, 32'd0, 32'd0);
        #1;
        check("br_flush", flush, 1);
        check("br_flush_pc", flush_pc, 32'h80);
        check("br_cm_valid", cm_valid, 1);
        check("br_cm_wr", cm_wr, 0);
        step();
        iss_valid = 1'b0;
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_tail", iss_tag, 0);
        check("fl_flush_low", flush, 0);
        check("fl_flush_pc", flush_pc, 0);
        check("fl_cm_valid", cm_valid, 0);

        // Store handshake with delayed ack and an rdy gap
        do_reset();
        set_issue(ROB_STORE, 5'd7, 1'b0, 32'd0, 32'd0); step();
        iss_valid = 1'b0;
        wb_valid = 2'b01; wb_tag = {2'd3, 2'd0}; wb_value = {32'd0, 32'h55};
        #1;
        check("st_not_ready", st_req, 0);
        step();
        wb_valid = '0;
        for (int i = 0; i < 3; i++) begin
            check("st_req_wait", st_req, 1);
            check("st_cm_wait", cm_valid, 0);
            step();
        end
        rdy = 1'b0;
        #1;
        check("st_rdy_low", st_req, 0);
        step();
        rdy = 1'b1;
        st_ack = 1'b1;
        #1;
        check("st_ack_cm", cm_valid, 1);
        check("st_ack_cm_wr", cm_wr, 0);
        check("st_ack_req", st_req, 1);
        step();
        st_ack = 1'b0;
        check("st_done_count", count, 0);
        check("st_done_req", st_req, 0);

        // Two ports on one tag: port 0 wins; then write to non-busy tag
        do_reset();
        set_issue(ROB_ALU, 5'd9, 1'b0, 32'd0, 32'd0); step();
        iss_valid = 1'b0;
        wb_valid = 2'b11; wb_tag = {2'd0, 2'd0}; wb_value = {32'hB, 32'hA};
        q_tag1 = 2'd0; q_tag2 = 2'd0;
        #1;
        check("dual_q_ready", q_ready1, 1);
        check("dual_q_value", q_value1, 32'hA);
        check("dual_q2_value", q_value2, 32'hA);
        step();
        wb_valid = '0;
        #1;
        check("dual_stored_rdy", q_ready1, 1);
        check("dual_stored_val", q_value1, 32'hA);
        check("dual_cm_value", cm_value, 32'hA);
        step();
        wb_valid = 2'b01; wb_tag = {2'd0, 2'd2}; wb_value = {32'd0, 32'h77};
        step();
        wb_valid = '0; q_tag1 = 2'd2;
        #1;
        check("nonbusy_ignored", q_ready1, 0);
        check("nonbusy_no_cm", cm_valid, 0);

        // Steady issue/retire with pointer wrap
        do_reset();
        set_issue(ROB_ALU, 5'd1, 1'b1, 32'd100, 32'd0); step();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            set_issue(ROB_ALU, 5'd1, 1'b1, 32'(101 + i), 32'd0);
            #1;
            check("wrap_cm_valid", cm_valid, 1);
            check("wrap_cm_tag", cm_tag, i % DEPTH);
            check("wrap_cm_value", cm_value, 100 + i);
            check("wrap_iss_tag", iss_tag, (i + 1) % DEPTH);
            check("wrap_count", count, 1);
            check("wrap_not_full", iss_ready, 1);
            check("wrap_not_empty", empty, 0);
            step();
        end
        iss_valid = 1'b0;
        step();
        check("wrap_drain_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer. Successor to the fixed 1-writeback ROB, with:
- configurable depth and writeback-port count;
- an occupancy counter for exact full/empty;
- mispredict flush carrying the stored recovery PC;
- a store-commit handshake to the LSB.

It sits between decoder/issue (allocation), RS/ALU/LSB (writeback), the register file (commit) and the fetch/predictor (flush).

## Interface
- DEPTH, 8, entries; power of two, 4..64; IDX_W = log2(DEPTH) derived locally
- WB_PORTS, 2, writeback ports, 1..4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state, suppresses cm_valid/flush/st_req
- iss_valid  in  1  allocate an entry this cycle
- iss_ready  out  1  count < DEPTH
- iss_type  in  3  ALU=0 LOAD=1 STORE=2 BRANCH=3 JUMP=4
- iss_rd  in  5  destination register
- iss_done  in  1  result already known (LUI/AUIPC/JAL)
- iss_value  in  32  result when iss_done
- iss_rec_pc  in  32  redirect PC if this entry mispredicts
- iss_tag  out  IDX_W  tag given to the allocating instruction (= tail)
- wb_valid  in  WB_PORTS  per-port writeback strobe
- wb_tag  in  WB_PORTS*IDX_W  packed tags, port 0 in LSBs
- wb_value  in  WB_PORTS*32  packed results
- wb_mispred  in  WB_PORTS  entry's prediction was wrong
- q_tag1, q_tag2  in  IDX_W  operand lookups
- q_ready1, q_ready2  out  1  value available
- q_value1, q_value2  out  32  value
- cm_valid  out  1  head retires this cycle
- cm_wr  out  1  retire writes register (type ALU/LOAD/JUMP, rd≠0)
- cm_rd  out  5;  cm_value  out  32;  cm_tag  out  IDX_W
- st_req  out  1  head is a ready STORE, asks LSB to perform it
- st_ack  in  1  LSB accepted the store
- flush  out  1  head mispredicted; flush pipeline
- flush_pc  out  32  recovery PC (0 when flush low)
- head_tag  out  IDX_W;  count  out  IDX_W+1;  empty  out  1

## Operation
- Circular buffer: head, tail, count. Per entry: busy, ready, mispred, type, rd, value, rec_pc.
- Issue: when iss_valid && iss_ready && rdy && !flush:
  - writes the tail entry;
  - ready = iss_done;
  - tail+1 mod DEPTH.
- iss_valid while full is ignored. The decoder must not do this; an assertion flags it.
- Writeback: for each valid port whose tag hits a busy entry, set ready, value and mispred. A hit on a non-busy entry is ignored. If two ports hit the same tag, the lowest port index wins.
- Retire is decided combinationally from head state:
  - non-STORE: head busy && ready → cm_valid=1.
  - STORE: head busy && ready → st_req=1. cm_valid = st_ack. Stall while ack is low.
  - mispred && ready at head → flush=1 and flush_pc = rec_pc. cm_valid=1 in the same cycle, so a JUMP still writes rd.
- Flush at the clock edge:
  - all busy bits cleared; head=tail=count=0;
  - same-cycle issue and writebacks are discarded.
- Query: q_ready is set if any of the following holds:
  - the entry is busy and ready;
  - a writeback this cycle matches the tag.

  Value priority: wb port 0 > higher ports > stored value. An issuing iss_done entry is not bypassed.
- count: +1 on accepted issue, −1 on retire. Both in one cycle leave it unchanged. It saturates at neither end; the protocol guarantees that.

## Timing
- Reset (async):
  - head=tail=count=0; all busy/ready cleared;
  - iss_ready=1, empty=1, every other output 0.
- Issue→entry visible: 1 cycle. Writeback→q_ready: 0 cycles (bypass); stored from next cycle.
- Writeback→retire: earliest the cycle after writeback (ready is registered).
- Retire rate: ≤1 per cycle. Store retire takes ≥1 cycle, extended by st_ack latency.
- Full and retire in the same cycle: iss_ready stays 0 that cycle (registered count). The slot frees next cycle.
- Wrap-around: pointers are IDX_W bits and wrap naturally. Full/empty come only from count.
- rdy low mid-store: st_req drops; the handshake resumes when rdy returns. The LSB must not ack while rdy is low.
- rst mid-flush or mid-store: reset dominates, and everything returns to reset values.

## Structure
- Package rob_pkg holds:
  - type encodings ROB_ALU/LOAD/STORE/BRANCH/JUMP;
  - the type width (3);
  - the entry struct {busy, ready, mispred, type, rd, value, rec_pc}.
- Sub-module rob_lookup: combinational tag query with writeback bypass. Instantiated twice (q1, q2), parametrised on DEPTH and WB_PORTS.

## Test plan
- DEPTH=4:
  - issue 4 ALU entries, then assert iss_valid again → iss_ready=0, count=4, tail unchanged;
  - wb tag 0 = 0x11 → next cycle cm_valid, cm_rd=issued rd, cm_value=0x11, count=3.
- Issue LUI with iss_done=1, value 0x12345000, rd=5 → retires 1 cycle later with cm_wr=1, no writeback needed.
- Issue a BRANCH, rec_pc 0x80, then 2 ALU entries; wb branch with wb_mispred=1 → flush=1, flush_pc=0x80 at head; next cycle count=0, empty=1.
- STORE at head, ready, st_ack held low 3 cycles → st_req=1 throughout, cm_valid=0. Ack raised → retires, cm_wr=0.
- Ports 0 and 1 write the same tag with 0xA and 0xB, q_tag1 = that tag → q_ready1=1, q_value1=0xA same cycle; stored value 0xA.
- Issue/retire at a steady 1 per cycle for 3×DEPTH cycles → tags wrap 7→0 (DEPTH=8), count constant, no spurious full/empty.
